// File: rtl/ts_record_serializer.sv
// Timestamp record serializer: buffers {id, start, end, delta} records in a small
// FIFO and streams each one as a 27-byte big-endian frame tagged with a 16-bit sequence number.
module ts_record_serializer #(
  parameter int          ID_W       = 4,
  parameter int          TS_W       = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_id,
  input  logic [TS_W-1:0] in_start_ts,
  input  logic [TS_W-1:0] in_end_ts,
  input  logic [TS_W-1:0] in_ts,
  output logic [7:0]      m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            m_tlast,
  output logic            busy
);

  localparam int         REC_W    = ID_W + 3 * TS_W;
  localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CNT_W    = PTR_W + 1;
  localparam int         FRAME_W  = 8 * 27;
  localparam logic [4:0] LAST_IDX = 5'd26;

  typedef enum logic {IDLE, SEND} state_t;

  // Frame layout: id(8) | seq(16) | start(64) | end(64) | delta(64), MSB first on the wire.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [REC_W-1:0] rec,
                                                    input logic [15:0]      seq);
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] st;
    logic [TS_W-1:0] en;
    logic [TS_W-1:0] dl;
    {id, st, en, dl} = rec;
    return {8'(id), seq, 64'(st), 64'(en), 64'(dl)};
  endfunction

  // ---- Stage p0: record FIFO ----
  logic [REC_W-1:0] mem_p0 [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_full  = (cnt_p0 == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_p0 == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_p0 <= cnt_p0 + CNT_W'(1);
        2'b01:   cnt_p0 <= cnt_p0 - CNT_W'(1);
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_p0[wr_ptr_p0] <= {in_id, in_start_ts, in_end_ts, in_ts};
  end

  // ---- Stage p1: frame shift register and byte stream ----
  state_t             state_p1;
  state_t             state_d;
  logic [FRAME_W-1:0] frame_p1;
  logic [4:0]         byte_idx_p1;
  logic [15:0]        seq_p1;
  logic               vld_p1;
  logic               last;

  assign vld_p1   = (state_p1 == SEND);
  assign last     = (byte_idx_p1 == LAST_IDX);
  assign m_tvalid = vld_p1;
  assign m_tdata  = frame_p1[FRAME_W-1 -: 8];
  assign m_tlast  = vld_p1 && last;
  assign busy     = !fifo_empty || vld_p1;

  always_comb begin
    state_d = state_p1;
    pop     = 1'b0;
    case (state_p1)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Chain the next record on the last-byte edge so records stream without a bubble.
        if (m_tready && last) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= IDLE;
      frame_p1    <= '0;
      byte_idx_p1 <= '0;
      seq_p1      <= SEQ_INIT;
    end else begin
      state_p1 <= state_d;
      if (pop) begin
        frame_p1    <= pack_frame(mem_p0[rd_ptr_p0], seq_p1);
        byte_idx_p1 <= '0;
        seq_p1      <= seq_p1 + 16'd1;
      end else if (vld_p1 && m_tready && !last) begin
        frame_p1    <= frame_p1 << 8;
        byte_idx_p1 <= byte_idx_p1 + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_ts_record_serializer.sv
// Directed bench for ts_record_serializer: framing, chaining, backpressure,
// FIFO-full flow control, sequence wrap and asynchronous reset mid-record.
module tb_ts_record_serializer;

  localparam int ID_W = 4;
  localparam int TS_W = 64;
  localparam int FD   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [ID_W-1:0] in_id;
  logic [TS_W-1:0] in_start_ts, in_end_ts, in_ts;
  logic [7:0]      m_tdata;
  logic            m_tvalid, m_tready, m_tlast, busy;

  logic            w_in_valid, w_in_ready;
  logic [ID_W-1:0] w_in_id;
  logic [TS_W-1:0] w_in_start_ts, w_in_end_ts, w_in_ts;
  logic [7:0]      w_m_tdata;
  logic            w_m_tvalid, w_m_tready, w_m_tlast, w_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ts_record_serializer #(.ID_W(ID_W), .TS_W(TS_W), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_ts(in_ts), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy)
  );

  // Second instance with the sequence counter preloaded near wrap.
  ts_record_serializer #(.ID_W(ID_W), .TS_W(TS_W), .FIFO_DEPTH(FD), .SEQ_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_id(w_in_id),
    .in_start_ts(w_in_start_ts), .in_end_ts(w_in_end_ts), .in_ts(w_in_ts), .m_tdata(w_m_tdata),
    .m_tvalid(w_m_tvalid), .m_tready(w_m_tready), .m_tlast(w_m_tlast), .busy(w_busy)
  );

  logic [7:0] got_b[$];
  logic       got_l[$];
  int         got_c[$];
  logic [7:0] exp_b[$];
  logic       exp_l[$];
  int         cyc = 0;
  int         stab_err = 0;
  logic       stall_q = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic       hold_l = 1'b0;

  always @(posedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      got_b.push_back(m_tdata);
      got_l.push_back(m_tlast);
      got_c.push_back(cyc);
    end
    if (stall_q && (!m_tvalid || m_tdata !== hold_d || m_tlast !== hold_l))
      stab_err <= stab_err + 1;
    stall_q <= rst_n && m_tvalid && !m_tready;
    hold_d  <= m_tdata;
    hold_l  <= m_tlast;
    cyc     <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    got_b.delete(); got_l.delete(); got_c.delete();
    exp_b.delete(); exp_l.delete();
  endtask

  task automatic add_exp(input logic [7:0] id, input logic [15:0] seq,
                         input logic [63:0] s, input logic [63:0] e, input logic [63:0] d);
    logic [215:0] f;
    f = {id, seq, s, e, d};
    for (int i = 0; i < 27; i++) begin
      exp_b.push_back(f[215 - 8 * i -: 8]);
      exp_l.push_back(i == 26);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 64'(got_b[i]), 64'(exp_b[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
  endtask

  task automatic wait_bytes(input string tag, input int n, input int bound);
    int g;
    g = 0;
    while (got_b.size() < n && g < bound) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_wait"}, 64'(got_b.size() >= n), 64'd1);
  endtask

  task automatic push_rec(input logic [ID_W-1:0] id, input logic [63:0] s,
                          input logic [63:0] e, input logic [63:0] d);
    int   g;
    logic ok;
    in_id = id; in_start_ts = s; in_end_ts = e; in_ts = d;
    in_valid = 1'b1;
    g = 0;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      g++;
    end while (!ok && g < 200);
    chk("push_accept", 64'(ok), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    w_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    in_valid = 1'b0; in_id = '0; in_start_ts = '0; in_end_ts = '0; in_ts = '0;
    m_tready = 1'b1;
    w_in_valid = 1'b0; w_in_id = '0; w_in_start_ts = '0; w_in_end_ts = '0; w_in_ts = '0;
    w_m_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast",  64'(m_tlast),  64'd0);
    chk("rst_tdata",  64'(m_tdata),  64'h00);
    chk("rst_busy",   64'(busy),     64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    clear_q();

    // Single record, latency and framing
    push_rec(4'h3, 64'h10, 64'h25, 64'h15);
    chk("t1_tvalid_edge1", 64'(m_tvalid), 64'd0);
    chk("t1_busy_edge1",   64'(busy),     64'd1);
    @(posedge clk); #1;
    chk("t1_tvalid_edge2", 64'(m_tvalid), 64'd1);
    chk("t1_first_byte",   64'(m_tdata),  64'h03);
    wait_bytes("t1", 27, 100);
    add_exp(8'h03, 16'h0000, 64'h10, 64'h25, 64'h15);
    cmp_stream("t1");
    chk("t1_duration", 64'(got_c[26] - got_c[0]), 64'd26);
    @(posedge clk); #1;
    chk("t1_idle_tvalid", 64'(m_tvalid), 64'd0);
    chk("t1_idle_busy",   64'(busy),     64'd0);

    // Back-to-back records
    apply_reset();
    push_rec(4'h1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CE00, 64'h11);
    push_rec(4'hA, 64'h1000, 64'h2000, 64'h1000);
    push_rec(4'hF, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F);
    wait_bytes("t2", 81, 200);
    add_exp(8'h01, 16'h0000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CE00, 64'h11);
    add_exp(8'h0A, 16'h0001, 64'h1000, 64'h2000, 64'h1000);
    add_exp(8'h0F, 16'h0002, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F);
    cmp_stream("t2");
    chk("t2_contiguous", 64'(got_c[80] - got_c[0]), 64'd80);

    // Random backpressure
    apply_reset();
    push_rec(4'h3, 64'h10, 64'h25, 64'h15);
    g = 0;
    while (got_b.size() < 27 && g < 600) begin
      m_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      g++;
    end
    m_tready = 1'b1;
    chk("t3_done", 64'(got_b.size()), 64'd27);
    add_exp(8'h03, 16'h0000, 64'h10, 64'h25, 64'h15);
    cmp_stream("t3");
    chk("t3_stable", 64'(stab_err), 64'd0);

    // FIFO full: first record moves into the serializer, freeing a slot for the 5th
    apply_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_rec(4'(i + 1), 64'(100 * i), 64'(100 * i + 7), 64'd7);
      add_exp(8'(i + 1), 16'(i), 64'(100 * i), 64'(100 * i + 7), 64'd7);
    end
    chk("t4_full_ready", 64'(in_ready), 64'd0);
    in_id = 4'h6; in_start_ts = 64'h600; in_end_ts = 64'h607; in_ts = 64'd7;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_stalled_ready", 64'(in_ready), 64'd0);
    chk("t4_stalled_tvalid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("t4_ready_back", 64'(in_ready), 64'd1);
    chk("t4_ready_after_pop", 64'(got_b.size()), 64'd27);
    @(posedge clk); #1;
    in_valid = 1'b0;
    add_exp(8'h06, 16'h0005, 64'h600, 64'h607, 64'd7);
    wait_bytes("t4", 162, 400);
    cmp_stream("t4");

    // Sequence wrap on the preloaded instance
    apply_reset();
    w_in_id = 4'h2; w_in_start_ts = 64'h5; w_in_end_ts = 64'h9; w_in_ts = 64'h4;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_id = 4'h7; w_in_start_ts = 64'h20; w_in_end_ts = 64'h30; w_in_ts = 64'h10;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    g = 0;
    while (!w_m_tvalid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("t5_tvalid", 64'(w_m_tvalid), 64'd1);
    for (int i = 0; i < 54; i++) begin
      got_b.push_back(w_m_tdata);
      got_l.push_back(w_m_tlast);
      @(posedge clk); #1;
    end
    add_exp(8'h02, 16'hFFFF, 64'h5, 64'h9, 64'h4);
    add_exp(8'h07, 16'h0000, 64'h20, 64'h30, 64'h10);
    cmp_stream("t5");

    // Asynchronous reset mid-record
    apply_reset();
    push_rec(4'h3, 64'h10, 64'h25, 64'h15);
    push_rec(4'h5, 64'h40, 64'h50, 64'h10);
    wait_bytes("t6_pre", 10, 100);
    rst_n = 1'b0;
    #1;
    chk("t6_async_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_async_tlast",  64'(m_tlast),  64'd0);
    chk("t6_async_busy",   64'(busy),     64'd0);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_post_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_post_busy",   64'(busy),     64'd0);
    chk("t6_no_more_bytes", 64'(got_b.size()), 64'd10);
    clear_q();
    push_rec(4'h9, 64'h10, 64'h25, 64'h15);
    wait_bytes("t6", 27, 100);
    add_exp(8'h09, 16'h0000, 64'h10, 64'h25, 64'h15);
    cmp_stream("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
